// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer.
// Contents:
//   op_t    - shift operation codes (SLL, SRL, SRA, ROTR)
//   state_t - 2-bit FSM state encodings (IDLE, SHIFT, DONE)
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// Single shared shift stage: shifts the operand by 2^k positions.
// Fill rules: SLL zero-fills the LSBs, SRL zero-fills the MSBs, SRA
// replicates the current MSB, ROTR wraps the low 2^k bits into the MSBs.
// Ports:
//   data    in  WIDTH  operand
//   k       in  SHW    stage index (shift by 2^k)
//   op      in  op_t   operation
//   shifted out WIDTH  stage result
module shift_stage
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   k,
  input  op_t              op,
  output logic [WIDTH-1:0] shifted
);

  // One constant-distance candidate per stage index; k selects one of them.
  logic [WIDTH-1:0] cand [SHW];

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
      localparam int S = 1 << gi;
      always_comb begin
        cand[gi] = data;
        case (op)
          OP_SLL:  cand[gi] = {data[WIDTH-1-S:0], {S{1'b0}}};
          OP_SRL:  cand[gi] = {{S{1'b0}}, data[WIDTH-1:S]};
          OP_SRA:  cand[gi] = {{S{data[WIDTH-1]}}, data[WIDTH-1:S]};
          OP_ROTR: cand[gi] = {data[S-1:0], data[WIDTH-1:S]};
          default: cand[gi] = data;
        endcase
      end
    end
  endgenerate

  always_comb begin
    shifted = data;
    for (int i = 0; i < SHW; i++) begin
      if (k == i[SHW-1:0]) shifted = cand[i];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter for the MIPS datapath. A request accepted
// over in_valid/in_ready is shifted by applying one shared 2^k stage per
// set bit of the shift amount (LSB first); the result is offered over
// out_valid/out_ready and held until taken.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   in_data, in_shamt   operand and shift amount
//   in_op               00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   out_valid/out_ready result handshake
//   out_data            shifted result
//   busy                high while SHIFT or DONE
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg,  data_next;
  logic [SHW-1:0]   shamt_reg, shamt_next;
  op_t              op_reg,    op_next;
  logic [SHW-1:0]   k_reg,     k_next;

  logic [WIDTH-1:0] stage_data;
  logic [SHW-1:0]   shamt_above;  // shamt_reg >> k: bit 0 is the current bit
  logic             last_step;    // no set bits remain above k

  shift_stage #(.WIDTH(WIDTH)) u_stage (
    .data    (data_reg),
    .k       (k_reg),
    .op      (op_reg),
    .shifted (stage_data)
  );

  assign shamt_above = shamt_reg >> k_reg;
  assign last_step   = ((shamt_above >> 1) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      data_reg  <= '0;
      shamt_reg <= '0;
      op_reg    <= OP_SLL;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      shamt_reg <= shamt_next;
      op_reg    <= op_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    shamt_next = shamt_reg;
    op_next    = op_reg;
    k_next     = k_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          data_next  = in_data;
          shamt_next = in_shamt;
          op_next    = op_t'(in_op);
          k_next     = '0;
          state_next = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shamt_above[0]) data_next = stage_data;
        // Stopping on the highest set bit keeps k within 0..SHW-1.
        if (last_step) state_next = ST_DONE;
        else           k_next     = k_reg + {{(SHW-1){1'b0}}, 1'b1};
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign out_data  = data_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  shift_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  op;
    logic [31:0] exp;
    int          lat;
    int          stall;
    bit          early;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    case (op)
      2'b00:   golden = d << s;
      2'b01:   golden = d >> s;
      2'b10:   golden = $signed(d) >>> s;
      default: golden = (d >> s) | (d << (6'd32 - {1'b0, s}));
    endcase
  endfunction

  function automatic int exp_latency(input logic [4:0] s);
    int m = -1;
    for (int i = 0; i < 5; i++) if (s[i]) m = i;
    return (m < 0) ? 1 : m + 2;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a clock edge. Drives one request, waits for the result,
  // optionally stalls, then completes the output handshake.
  task automatic run_req(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                         input logic [31:0] exp, input int lat, input int stall, input bit early);
    int waited;
    logic [31:0] want;
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op;
    exp_q.push_back(exp);
    out_ready = early;
    tick();
    // Scramble inputs after the accept edge; they must not matter.
    in_valid = 1'b0; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
    waited = 1;
    while (!out_valid && waited < 40) begin
      tick();
      waited++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL timeout: out_valid not seen after %0d cycles, required 1", waited);
      void'(exp_q.pop_front());
      out_ready = 1'b0;
      return;
    end
    check("latency", waited, lat);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) tick();
    check("held_valid", {31'd0, out_valid}, 32'd1);
    want = exp_q.pop_front();
    check("out_data", out_data, want);
    $display("[TB] op=%0d data=%h shamt=%0d -> %h (exp %h) lat=%0d", op, d, s, out_data, want, waited);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ready_after_done", {31'd0, in_ready}, 32'd1);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] hold;
    logic [31:0] rd;
    logic [4:0]  rs;
    logic [1:0]  ro;

    vecs.push_back('{32'h0000_0001, 5'd5,  2'b00, 32'h0000_0020, 4, 0, 1'b0});
    vecs.push_back('{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 6, 0, 1'b0});
    vecs.push_back('{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 6, 2, 1'b0});
    vecs.push_back('{32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456, 5, 0, 1'b1});
    vecs.push_back('{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1, 0, 1'b0});
    vecs.push_back('{32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678, 1, 1, 1'b0});
    vecs.push_back('{32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678, 1, 0, 1'b1});
    vecs.push_back('{32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 1, 0, 1'b0});
    vecs.push_back('{32'h8765_4321, 5'd2,  2'b10, 32'hE1D9_50C8, 3, 0, 1'b0});
    vecs.push_back('{32'h8765_4321, 5'd1,  2'b11, 32'hC3B2_A190, 2, 0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 5'd16, 2'b00, 32'hFFFF_0000, 6, 3, 1'b0});
    vecs.push_back('{32'h0000_FFFF, 5'd4,  2'b11, 32'hF000_0FFF, 4, 0, 1'b1});
    vecs.push_back('{32'h7FFF_FFFF, 5'd30, 2'b10, 32'h0000_0001, 6, 0, 1'b0});

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++)
      run_req(vecs[i].d, vecs[i].s, vecs[i].op, vecs[i].exp, vecs[i].lat, vecs[i].stall, vecs[i].early);

    // Back-pressure: result held 10 cycles while a competing request is ignored.
    in_valid = 1'b1; in_data = 32'hA5A5_0F0F; in_shamt = 5'd13; in_op = 2'b10;
    exp_q.push_back(32'hFFFD_2D28);
    tick();
    in_data = 32'h0000_0001; in_shamt = 5'd3; in_op = 2'b00;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    hold = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data",  out_data, hold);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    $display("[TB] backpressure op=2 data=a5a50f0f shamt=13 -> %h (exp %h)", out_data, hold);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_no_accept", {31'd0, busy}, 32'd0);

    // Reset in the middle of a SHIFT sequence.
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd16; in_op = 2'b01;
    exp_q.push_back(32'h0000_FFFF);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data",  out_data,           32'd0);
    check("mid_rst_busy",      {31'd0, busy},      32'd0);
    void'(exp_q.pop_front());
    tick();
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (out_valid) seen = 1'b1;
      end
      check("no_valid_after_rst", {31'd0, seen}, 32'd0);
    end
    $display("[TB] reset mid-shift: request dropped");

    // Random regression against the golden model.
    for (int n = 0; n < 1000; n++) begin
      rd = $urandom;
      rs = 5'($urandom);
      ro = 2'($urandom);
      if (n < 32) rs = 5'(n);
      run_req(rd, rs, ro, golden(rd, rs, ro), exp_latency(rs), int'($urandom_range(0, 3)), 1'($urandom));
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule
